// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake, byte/half lane steering,
// load extension, pipeline stall generation, misalignment and timeout detection.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busywait,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [29:0]       waddr_q, waddr_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              fault_q, fault_d;
  logic              req_q, req_d;

  logic              req_c;
  logic              aligned_c;
  logic [31:0]       st_wdata_c;
  logic [3:0]        st_wstrb_c;
  logic [31:0]       lane_c;
  logic [31:0]       ld_ext_c;

  assign read_data    = rdata_q;
  assign misaligned   = mis_q;
  assign access_fault = fault_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = {waddr_q, 2'b00};
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;

  // Request decode: size in funct3[1:0] (2'b11 falls into word), alignment and store lanes.
  always_comb begin
    req_c      = mem_read | mem_write;
    aligned_c  = 1'b1;
    st_wdata_c = write_data;
    st_wstrb_c = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata_c = {4{write_data[7:0]}};
        st_wstrb_c = 4'b0001 << address[1:0];
      end
      2'b01: begin
        aligned_c  = (address[0] == 1'b0);
        st_wdata_c = {2{write_data[15:0]}};
        st_wstrb_c = 4'b0011 << address[1:0];
      end
      default: begin
        aligned_c  = (address[1:0] == 2'b00);
      end
    endcase
    if (!mem_write) begin
      st_wstrb_c = 4'b0000;
    end
  end

  // Load lane extraction at the latched offset, then sign/zero extension.
  always_comb begin
    lane_c   = mem_rdata >> {off_q, 3'b000};
    ld_ext_c = mem_rdata;
    case (f3_q[1:0])
      2'b00:   ld_ext_c = {{24{~f3_q[2] & lane_c[7]}}, lane_c[7:0]};
      2'b01:   ld_ext_c = {{16{~f3_q[2] & lane_c[15]}}, lane_c[15:0]};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    f3_d     = f3_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mis_d    = 1'b0;
    fault_d  = 1'b0;
    req_d    = 1'b0;
    busywait = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          busywait = 1'b1;
          if (aligned_c) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = mem_write;
            waddr_d = address[31:2];
            f3_d    = funct3;
            off_d   = address[1:0];
            wdata_d = st_wdata_c;
            wstrb_d = st_wstrb_c;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            mis_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        busywait = 1'b1;
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = ld_ext_c;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          req_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl (TIMEOUT_CYCLES = 4).
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic        busywait;
  logic [31:0] read_data;
  logic        misaligned, access_fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .address      (address),
    .write_data   (write_data),
    .busywait     (busywait),
    .read_data    (read_data),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          ack;     // ACCESS cycle that acks, 0 = never
    logic [31:0] rdata;
    int          stall;
    int          acc;
    logic        mis;
    logic        flt;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  estrb;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one request and follows it to its DONE cycle, checking every observable.
  task automatic run_vec(input vec_t v, input string nm, output int dcyc);
    int  stall = 0;
    int  acc = 0;
    bit  done = 1'b0;
    dcyc = 0;
    @(negedge clk);
    mem_read   = v.rd;
    mem_write  = v.wr;
    funct3     = v.f3;
    address    = v.addr;
    write_data = v.wd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (busywait) begin
        stall++;
        if (mem_req) begin
          acc++;
          if (acc == 1) begin
            chk({nm, " mem_addr"}, mem_addr, v.eaddr);
            chk({nm, " mem_we"}, 32'(mem_we), 32'(v.wr));
            chk({nm, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.estrb));
            if (v.wr) chk({nm, " mem_wdata"}, mem_wdata, v.ewdata);
          end
          if (acc == v.ack) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
          end
        end
      end else begin
        done = 1'b1;
        dcyc = cyc;
        chk({nm, " stall_cycles"}, 32'(stall), 32'(v.stall));
        chk({nm, " access_cycles"}, 32'(acc), 32'(v.acc));
        chk({nm, " misaligned"}, 32'(misaligned), 32'(v.mis));
        chk({nm, " access_fault"}, 32'(access_fault), 32'(v.flt));
        chk({nm, " read_data"}, read_data, v.erd);
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s no_done: busywait stuck after 40 cycles", nm);
    end
  endtask

  initial begin
    int d0, d1;
    vec_t v;

    //        rd wr f3      addr          wd            ack rdata         st ac mis flt eaddr         ewdata        strb     erd
    vecs[0]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 4, 3, 0, 0, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF};
    vecs[1]  = '{0, 1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0,        2, 1, 0, 0, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 0, 3'b001, 32'h0000_0302, 32'h0,        1, 32'h8001_1234, 2, 1, 0, 0, 32'h0000_0300, 32'h0,        4'b0000, 32'hFFFF_8001};
    vecs[3]  = '{1, 0, 3'b101, 32'h0000_0302, 32'h0,        2, 32'h8001_1234, 3, 2, 0, 0, 32'h0000_0300, 32'h0,        4'b0000, 32'h0000_8001};
    vecs[4]  = '{1, 0, 3'b000, 32'h0000_0301, 32'h0,        1, 32'h8001_1234, 2, 1, 0, 0, 32'h0000_0300, 32'h0,        4'b0000, 32'h0000_0012};
    vecs[5]  = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        1, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0000_0012};
    vecs[6]  = '{1, 0, 3'b001, 32'h0000_0103, 32'h0,        1, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0000_0012};
    vecs[7]  = '{1, 0, 3'b010, 32'h0000_0400, 32'h0,        0, 32'h0,        5, 4, 0, 1, 32'h0000_0400, 32'h0,        4'b0000, 32'h0000_0000};
    vecs[8]  = '{0, 1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 2, 32'h0,        3, 2, 0, 0, 32'h0000_0204, 32'hABCD_ABCD, 4'b1100, 32'h0000_0000};
    vecs[9]  = '{1, 0, 3'b100, 32'h0000_0503, 32'h0,        1, 32'hF122_3344, 2, 1, 0, 0, 32'h0000_0500, 32'h0,        4'b0000, 32'h0000_00F1};
    vecs[10] = '{1, 0, 3'b000, 32'h0000_0503, 32'h0,        1, 32'hF122_3344, 2, 1, 0, 0, 32'h0000_0500, 32'h0,        4'b0000, 32'hFFFF_FFF1};
    vecs[11] = '{0, 1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 4, 32'h0,        5, 4, 0, 0, 32'h0000_0600, 32'hCAFE_F00D, 4'b1111, 32'hFFFF_FFF1};
    vecs[12] = '{1, 0, 3'b111, 32'h0000_0702, 32'h0,        1, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FFF1};
    vecs[13] = '{1, 1, 3'b000, 32'h0000_0001, 32'h0000_005A, 1, 32'h1111_1111, 2, 1, 0, 0, 32'h0000_0000, 32'h5A5A_5A5A, 4'b0010, 32'hFFFF_FFF1};

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    address = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busywait", 32'(busywait), 32'd0);
    chk("rst read_data", read_data, 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst access_fault", 32'(access_fault), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), d0);
    end

    // Timeout on a load, then a stray ack while idle must have no effect.
    v = '{1, 0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0, 5, 4, 0, 1,
          32'h0000_0040, 32'h0, 4'b0000, 32'h0};
    run_vec(v, "timeout", d0);
    mem_read = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_ack busywait", 32'(busywait), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack mem_req", 32'(mem_req), 32'd0);
    chk("late_ack read_data", read_data, 32'd0);
    chk("late_ack access_fault", 32'(access_fault), 32'd0);

    // Reset during the second ACCESS cycle of a store, with an ack pending.
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; address = 32'h0000_0800; write_data = 32'h1357_9BDF;
    #1;
    chk("rstmid req_cycle busywait", 32'(busywait), 32'd1);
    @(negedge clk); #1;
    chk("rstmid access1 mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); #1;
    chk("rstmid access2 mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
    reset = 1'b1;
    #1;
    chk("rstmid mem_req", 32'(mem_req), 32'd0);
    chk("rstmid mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rstmid mem_addr", mem_addr, 32'd0);
    mem_write = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstmid idle busywait", 32'(busywait), 32'd0);
    @(negedge clk); #1;
    chk("rstmid after mem_req", 32'(mem_req), 32'd0);
    chk("rstmid after access_fault", 32'(access_fault), 32'd0);
    chk("rstmid after read_data", read_data, 32'd0);

    // Back-to-back loads with the request held through DONE.
    v = '{1, 0, 3'b010, 32'h0000_0010, 32'h0, 1, 32'h0102_0304, 2, 1, 0, 0,
          32'h0000_0010, 32'h0, 4'b0000, 32'h0102_0304};
    run_vec(v, "b2b_first", d0);
    v = '{1, 0, 3'b010, 32'h0000_0014, 32'h0, 1, 32'hA0B0_C0D0, 2, 1, 0, 0,
          32'h0000_0014, 32'h0, 4'b0000, 32'hA0B0_C0D0};
    run_vec(v, "b2b_second", d1);
    chk("b2b done_spacing", 32'(d1 - d0), 32'd3);
    mem_read = 1'b0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
